groestl_scan_ctrl: RTL and testbench

- Parametrised nonce-scan controller for the double-Groestl mining datapath. Successor to the single-pipeline hasher front end.
- Holds the 76-byte header prefix and a 64-bit target, both loaded over Avalon-MM.
- Dispatches nonces from a programmable inclusive range across NUM_LANES external hash lanes. Compares each lane's returned hash against the target.
- Queues every winning nonce in a result FIFO that the CPU drains, instead of keeping only one golden nonce.

---
 rtl/groestl_scan_pkg.sv | 42 ++++
 rtl/groestl_scan_ctrl_fifo.sv | 64 ++++++
 rtl/groestl_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_groestl_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/groestl_scan_pkg.sv
// Shared constants for the double-Groestl nonce-scan controller:
// register map, status/control bit positions and the scan FSM state type.
package groestl_scan_pkg;

  localparam int unsigned MSG_WORDS = 19;

  // Write-side register addresses
  localparam int unsigned ADDR_TARGET_HI   = 'h18;
  localparam int unsigned ADDR_TARGET_LO   = 'h19;
  localparam int unsigned ADDR_NONCE_START = 'h1A;
  localparam int unsigned ADDR_NONCE_END   = 'h1B;
  localparam int unsigned ADDR_CTRL        = 'h1C;

  // Read-side register addresses
  localparam int unsigned ADDR_FIFO_RD   = 'h00;
  localparam int unsigned ADDR_STATUS_RD = 'h01;
  localparam int unsigned ADDR_START_RD  = 'h02;
  localparam int unsigned ADDR_NEXT_RD   = 'h03;
  localparam int unsigned ADDR_OUTST_RD  = 'h04;

  // Control register bits
  localparam int unsigned CTRL_START      = 0;
  localparam int unsigned CTRL_ABORT      = 1;
  localparam int unsigned CTRL_FIFO_CLEAR = 2;
  localparam int unsigned CTRL_IRQ_EN     = 3;

  // Status register bits / fields
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_OVERFLOW  = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_FOUND_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } scan_state_e;

endpackage

// File: rtl/groestl_scan_ctrl_fifo.sv
// scan_result_fifo: synchronous FIFO holding winning nonces.
// Ports: clk/reset, push/din, pop/head_c (combinational head), clear (empties
// and clears overflow, wins over push/pop), clr_ovf (clears overflow only),
// count, full_c, empty_c, overflow (sticky, set on a push that is dropped).
module scan_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic                     clr_ovf,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full_c,
  output logic                     empty_c,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign head_c  = mem[rd_ptr];
  assign do_pop  = pop && !empty_c;
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push && (!full_c || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
      if (push && !do_push) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/groestl_scan_ctrl.sv
// groestl_scan_ctrl: nonce-scan controller for NUM_LANES double-Groestl lanes.
// Ports: clk/reset; Avalon-MM slave (address, writedata, write, read,
// chipselect, readdata); msg_out header broadcast; per-lane handshake
// (lane_ready/start/nonce issue side, lane_done/hash/ack result side);
// lane_flush abort pulse; irq (FIFO not empty and enabled).
module groestl_scan_ctrl
  import groestl_scan_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AW         = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW-1:0]             address,
  input  logic [31:0]               writedata,
  input  logic                      write,
  input  logic                      read,
  input  logic                      chipselect,
  output logic [31:0]               readdata,
  output logic [MSG_WORDS*32-1:0]   msg_out,
  input  logic [NUM_LANES-1:0]      lane_ready,
  output logic [NUM_LANES-1:0]      lane_start,
  output logic [32*NUM_LANES-1:0]   lane_nonce,
  input  logic [NUM_LANES-1:0]      lane_done,
  input  logic [64*NUM_LANES-1:0]   lane_hash,
  output logic [NUM_LANES-1:0]      lane_ack,
  output logic                      lane_flush,
  output logic                      irq
);

  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  scan_state_e          state;
  logic [31:0]          target_hi, target_lo, nonce_start, nonce_end, next_nonce;
  logic                 irq_en, done;
  logic [15:0]          found_total;
  logic [NUM_LANES-1:0] busy_lane;
  logic [31:0]          tag [NUM_LANES];
  logic [LW-1:0]        rr_ptr;

  logic          wr_en, rd_en, ctrl_wr, start_c, abort_c, clear_c, busy_c;
  logic          iss_c, acc_c, win_c, push_c, pop_c;
  logic [LW-1:0] iss_idx, acc_idx;
  int unsigned   scan_j;
  logic [31:0]   head_c, status_c, rd_mux_c, outstanding_c;
  logic [CW-1:0] fifo_count;
  logic          fifo_full_c, fifo_empty_c, overflow;

  assign wr_en   = write && chipselect;
  assign rd_en   = read && chipselect;
  assign ctrl_wr = wr_en && (address == AW'(ADDR_CTRL));
  assign abort_c = ctrl_wr && writedata[CTRL_ABORT];
  assign clear_c = ctrl_wr && writedata[CTRL_FIFO_CLEAR];
  assign busy_c  = (state == S_DISPATCH) || (state == S_DRAIN);
  // Start only from a quiescent state; abort in the same write wins
  assign start_c = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_ABORT] && !busy_c;

  // Round-robin issue: first ready, non-busy lane starting at rr_ptr
  always_comb begin
    iss_c   = 1'b0;
    iss_idx = '0;
    scan_j  = 0;
    if (state == S_DISPATCH && !abort_c) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        scan_j = 32'(rr_ptr) + 32'(k);
        if (scan_j >= NUM_LANES) scan_j = scan_j - NUM_LANES;
        if (!iss_c && lane_ready[scan_j] && !busy_lane[scan_j]) begin
          iss_c   = 1'b1;
          iss_idx = LW'(scan_j);
        end
      end
    end
  end

  // Fixed-priority result accept; lanes acked last cycle still show done, so skip them
  always_comb begin
    acc_c   = 1'b0;
    acc_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_done[i] && !lane_ack[i]) begin
        acc_c   = 1'b1;
        acc_idx = LW'(i);
      end
    end
  end

  assign win_c  = lane_hash[64*acc_idx +: 64] <= {target_hi, target_lo};
  assign push_c = acc_c && win_c && !abort_c;
  assign pop_c  = rd_en && (address == AW'(ADDR_FIFO_RD)) && !fifo_empty_c;

  always_comb begin
    outstanding_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (busy_lane[i]) outstanding_c = outstanding_c + 32'd1;
  end

  always_comb begin
    status_c                           = '0;
    status_c[STAT_BUSY]                = busy_c;
    status_c[STAT_DONE]                = done;
    status_c[STAT_EMPTY]               = fifo_empty_c;
    status_c[STAT_OVERFLOW]            = overflow;
    status_c[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
    status_c[STAT_FOUND_LSB +: 16]     = found_total;
  end

  always_comb begin
    rd_mux_c = '0;
    case (address)
      AW'(ADDR_FIFO_RD):   rd_mux_c = fifo_empty_c ? 32'd0 : head_c;
      AW'(ADDR_STATUS_RD): rd_mux_c = status_c;
      AW'(ADDR_START_RD):  rd_mux_c = nonce_start;
      AW'(ADDR_NEXT_RD):   rd_mux_c = next_nonce;
      AW'(ADDR_OUTST_RD):  rd_mux_c = outstanding_c;
      default:             rd_mux_c = '0;
    endcase
  end

  scan_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_c),
    .pop      (pop_c),
    .clear    (clear_c),
    .clr_ovf  (start_c),
    .din      (tag[acc_idx]),
    .head_c   (head_c),
    .count    (fifo_count),
    .full_c   (fifo_full_c),
    .empty_c  (fifo_empty_c),
    .overflow (overflow)
  );

  // Register file, scan FSM, lane handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      readdata    <= '0;
      msg_out     <= '0;
      target_hi   <= '0;
      target_lo   <= '0;
      nonce_start <= '0;
      nonce_end   <= '0;
      next_nonce  <= '0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
      done        <= 1'b0;
      found_total <= '0;
      busy_lane   <= '0;
      rr_ptr      <= '0;
      lane_start  <= '0;
      lane_nonce  <= '0;
      lane_ack    <= '0;
      lane_flush  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) tag[i] <= '0;
    end else begin
      lane_start <= '0;
      lane_ack   <= '0;
      lane_flush <= 1'b0;
      irq        <= irq_en && !fifo_empty_c;

      if (wr_en) begin
        for (int k = 0; k < MSG_WORDS; k++)
          if (address == AW'(k)) msg_out[32*k +: 32] <= writedata;
        case (address)
          AW'(ADDR_TARGET_HI):   target_hi   <= writedata;
          AW'(ADDR_TARGET_LO):   target_lo   <= writedata;
          AW'(ADDR_NONCE_START): nonce_start <= writedata;
          AW'(ADDR_NONCE_END):   nonce_end   <= writedata;
          AW'(ADDR_CTRL):        irq_en      <= writedata[CTRL_IRQ_EN];
          default: ;
        endcase
      end

      if (rd_en) readdata <= rd_mux_c;

      if (acc_c) begin
        lane_ack[acc_idx]  <= 1'b1;
        busy_lane[acc_idx] <= 1'b0;
        if (push_c && found_total != 16'hFFFF) found_total <= found_total + 16'd1;
      end

      if (abort_c) begin
        lane_flush <= 1'b1;
        busy_lane  <= '0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_c) begin
              next_nonce  <= nonce_start;
              found_total <= '0;
              done        <= 1'b0;
              rr_ptr      <= '0;
              state       <= S_DISPATCH;
            end
          end
          S_DISPATCH: begin
            if (iss_c) begin
              lane_start[iss_idx]          <= 1'b1;
              lane_nonce[32*iss_idx +: 32] <= next_nonce;
              busy_lane[iss_idx]           <= 1'b1;
              tag[iss_idx]                 <= next_nonce;
              next_nonce                   <= next_nonce + 32'd1;
              rr_ptr <= (32'(iss_idx) == NUM_LANES - 1) ? '0 : iss_idx + LW'(1);
              // Inclusive end; 32-bit increment handles wrap past 0xFFFFFFFF
              if (next_nonce == nonce_end) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (busy_lane == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_groestl_scan_ctrl.sv
// Self-checking bench for groestl_scan_ctrl with two behavioural lanes.
// Lanes return hash = all-ones (mode 0) or {32'h0, nonce} (mode 1) after a
// fixed latency; lane_go=0 holds finished results back until released.
module tb_groestl_scan_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   address;
  logic [31:0]  writedata;
  logic         write, read, chipselect;
  logic [31:0]  readdata;
  logic [607:0] msg_out;
  logic [1:0]   lane_ready, lane_start, lane_done, lane_ack;
  logic [63:0]  lane_nonce;
  logic [127:0] lane_hash;
  logic         lane_flush, irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  groestl_scan_ctrl #(.NUM_LANES(2), .FIFO_DEPTH(8), .AW(6)) dut (
    .clk(clk), .reset(reset), .address(address), .writedata(writedata),
    .write(write), .read(read), .chipselect(chipselect), .readdata(readdata),
    .msg_out(msg_out), .lane_ready(lane_ready), .lane_start(lane_start),
    .lane_nonce(lane_nonce), .lane_done(lane_done), .lane_hash(lane_hash),
    .lane_ack(lane_ack), .lane_flush(lane_flush), .irq(irq)
  );

  // Lane model
  int          hash_mode = 0;
  logic        lane_go = 1'b1;
  logic [1:0]  m_pend;
  logic [3:0]  m_cnt [2];
  logic [31:0] m_nonce [2];
  logic [63:0] m_hash [2];

  assign lane_ready = 2'b11;
  assign lane_hash  = {m_hash[1], m_hash[0]};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend    <= '0;
      lane_done <= '0;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= '0; m_nonce[i] <= '0; m_hash[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (lane_ack[i]) lane_done[i] <= 1'b0;
        if (lane_flush) begin
          m_pend[i] <= 1'b0; lane_done[i] <= 1'b0;
        end else if (lane_start[i]) begin
          m_pend[i]  <= 1'b1;
          m_cnt[i]   <= 4'd2;
          m_nonce[i] <= lane_nonce[32*i +: 32];
        end else if (m_pend[i]) begin
          if (m_cnt[i] != 0) m_cnt[i] <= m_cnt[i] - 4'd1;
          else if (lane_go) begin
            lane_done[i] <= 1'b1;
            m_pend[i]    <= 1'b0;
            m_hash[i]    <= (hash_mode == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'h0, m_nonce[i]};
          end
        end
      end
    end
  end

  // Event logs
  int          cyc = 0;
  int          flush_cnt = 0;
  int          iss_lane[$];
  logic [31:0] iss_nonce[$];
  int          ack_lane[$];
  int          ack_cyc[$];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (lane_start[i]) begin
          iss_lane.push_back(i);
          iss_nonce.push_back(lane_nonce[32*i +: 32]);
        end
        if (lane_ack[i]) begin
          ack_lane.push_back(i);
          ack_cyc.push_back(cyc);
        end
      end
      if (lane_flush) flush_cnt++;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
    @(negedge clk);
    write = 1'b0; chipselect = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1; chipselect = 1'b1;
    @(negedge clk);
    read = 1'b0; chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, {32'h0, d}, {32'h0, exp});
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_rd(6'h01, s);
      n++;
    end while (!s[1] && n < 400);
    check(tag, {63'h0, s[1]}, 64'h1);
  endtask

  task automatic scan(input logic [31:0] s, input logic [31:0] e, input logic [31:0] ctrl);
    bus_wr(6'h1A, s);
    bus_wr(6'h1B, e);
    iss_lane.delete(); iss_nonce.delete();
    ack_lane.delete(); ack_cyc.delete();
    bus_wr(6'h1C, ctrl);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_n [4];
    reset = 1'b1; address = '0; writedata = '0;
    write = 1'b0; read = 1'b0; chipselect = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_readdata", {32'h0, readdata}, 64'h0);
    check("rst_outputs", {59'h0, lane_start, lane_ack, lane_flush}, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    reset = 1'b0;
    rd_chk("rst_status", 6'h01, 32'h0000_0004);

    // msg and unmapped write
    bus_wr(6'h00, 32'hA5A5_0000);
    bus_wr(6'h12, 32'h1234_5678);
    bus_wr(6'h20, 32'hDEAD_BEEF);
    check("msg_w0", {32'h0, msg_out[31:0]}, 64'hA5A5_0000);
    check("msg_w18", {32'h0, msg_out[607:576]}, 64'h1234_5678);

    // T1: 0x10..0x13, target 0, all-ones hashes lose
    scan(32'h10, 32'h13, 32'h1);
    wait_done("t1_done");
    check("t1_issue_cnt", 64'(iss_lane.size()), 64'd4);
    for (int i = 0; i < 4 && i < iss_lane.size(); i++) begin
      check($sformatf("t1_lane%0d", i), 64'(iss_lane[i]), 64'(i % 2));
      check($sformatf("t1_nonce%0d", i), {32'h0, iss_nonce[i]}, 64'h10 + 64'(i));
    end
    rd_chk("t1_status", 6'h01, 32'h0000_0006);
    rd_chk("t1_start_rd", 6'h02, 32'h10);
    rd_chk("t1_next_rd", 6'h03, 32'h14);

    // T2: wrapping range, all win
    bus_wr(6'h18, 32'hFFFF_FFFF);
    bus_wr(6'h19, 32'hFFFF_FFFF);
    scan(32'hFFFF_FFFE, 32'h1, 32'h9);
    wait_done("t2_done");
    exp_n = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    check("t2_issue_cnt", 64'(iss_nonce.size()), 64'd4);
    for (int i = 0; i < 4 && i < iss_nonce.size(); i++)
      check($sformatf("t2_nonce%0d", i), {32'h0, iss_nonce[i]}, {32'h0, exp_n[i]});
    rd_chk("t2_status_full", 6'h01, 32'h0004_0402);
    check("t2_irq_on", {63'h0, irq}, 64'h1);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("t2_pop%0d", i), 6'h00, exp_n[i]);
    rd_chk("t2_status_empty", 6'h01, 32'h0004_0006);
    rd_chk("t2_pop_empty", 6'h00, 32'h0);
    check("t2_irq_off", {63'h0, irq}, 64'h0);

    // T3: 10 wins into 8 entries -> overflow, then clear
    scan(32'h200, 32'h209, 32'h9);
    wait_done("t3_done");
    rd_chk("t3_status_ovf", 6'h01, 32'h000A_080A);
    bus_wr(6'h1C, 32'hC);
    rd_chk("t3_status_clr", 6'h01, 32'h000A_0006);

    // T4: hash == target wins, target+1 loses but is still acked
    hash_mode = 1;
    bus_wr(6'h18, 32'h0);
    bus_wr(6'h19, 32'h20);
    scan(32'h20, 32'h21, 32'h9);
    wait_done("t4_done");
    check("t4_ack_cnt", 64'(ack_lane.size()), 64'd2);
    rd_chk("t4_status", 6'h01, 32'h0001_0102);

    // T5: abort with both lanes outstanding; FIFO entry 0x20 retained
    lane_go = 1'b0;
    scan(32'h100, 32'h1FF, 32'h9);
    repeat (8) @(negedge clk);
    rd_chk("t5_outst_busy", 6'h04, 32'd2);
    rd_chk("t5_status_busy", 6'h01, 32'h0000_0101);
    flush_cnt = 0;
    bus_wr(6'h1C, 32'hA);
    rd_chk("t5_status_idle", 6'h01, 32'h0000_0100);
    rd_chk("t5_outst_idle", 6'h04, 32'd0);
    check("t5_flush_cnt", 64'(flush_cnt), 64'd1);
    check("t5_irq", {63'h0, irq}, 64'h1);
    rd_chk("t5_retained", 6'h00, 32'h20);

    // T6: both lanes finish in the same cycle
    hash_mode = 0;
    bus_wr(6'h18, 32'hFFFF_FFFF);
    bus_wr(6'h19, 32'hFFFF_FFFF);
    scan(32'h40, 32'h41, 32'h9);
    repeat (8) @(negedge clk);
    lane_go = 1'b1;
    wait_done("t6_done");
    check("t6_ack_cnt", 64'(ack_lane.size()), 64'd2);
    if (ack_lane.size() == 2) begin
      check("t6_ack_first", 64'(ack_lane[0]), 64'd0);
      check("t6_ack_second", 64'(ack_lane[1]), 64'd1);
      check("t6_ack_gap", 64'(ack_cyc[1] - ack_cyc[0]), 64'd1);
    end
    rd_chk("t6_pop0", 6'h00, 32'h40);
    rd_chk("t6_pop1", 6'h00, 32'h41);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
